// File: rtl/mult_seq_32.sv
// Sequential 32x32 signed radix-2 Booth multiplier; one step per clock through a carry-select adder.
// Optional MULT_HI_OUT_EN adds data_result_hi carrying product[63:32].
module csa_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [16:0] lo_s;
    logic [16:0] hi0;
    logic [16:0] hi1;

    assign lo_s = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'b0, cin};
    assign hi0  = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi1  = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign sum  = {(lo_s[16] ? hi1[15:0] : hi0[15:0]), lo_s[15:0]};
    assign cout = lo_s[16] ? hi1[16] : hi0[16];
endmodule

module mult_seq_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ctrl_mult,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic        busy,
    output logic        data_resultRDY,
    output logic [31:0] data_result,
    output logic        data_exception
`ifdef MULT_HI_OUT_EN
    ,
    output logic [31:0] data_result_hi
`endif
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [31:0]      m;
    logic [32:0]      hi;
    logic [31:0]      lo;
    logic             q;
    logic [CNT_W-1:0] cnt;

    logic [31:0] bx;
    logic        cin;
    logic        add;
    logic [31:0] sum;
    logic        cout;
    logic [32:0] sum33;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        exc_n;

    always_comb begin
        bx  = m;
        cin = 1'b0;
        add = 1'b0;
        unique case ({lo[0], q})
            2'b01: begin
                bx  = m;
                add = 1'b1;
            end
            2'b10: begin
                bx  = ~m;
                cin = 1'b1;
                add = 1'b1;
            end
            default: ;
        endcase
    end

    csa_32 u_csa (
        .a   (hi[31:0]),
        .b   (bx),
        .cin (cin),
        .sum (sum),
        .cout(cout)
    );

    // Bit 32 rebuilt from the carry gives a true 33-bit signed add, so M = -2^31 works.
    assign sum33 = add ? {hi[32] ^ bx[31] ^ cout, sum} : hi;
    assign hi_n  = sum33[32:1];
    assign lo_n  = {sum33[0], lo[31:1]};
    assign exc_n = (hi_n != {32{lo_n[31]}});

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            m              <= '0;
            hi             <= '0;
            lo             <= '0;
            q              <= 1'b0;
            cnt            <= '0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULT_HI_OUT_EN
            data_result_hi <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    data_resultRDY <= 1'b0;
                    if (ctrl_mult) begin
                        m     <= data_operandA;
                        hi    <= '0;
                        lo    <= data_operandB;
                        q     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    hi  <= {sum33[32], hi_n};
                    lo  <= lo_n;
                    q   <= lo[0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= lo_n;
                        data_exception <= exc_n;
`ifdef MULT_HI_OUT_EN
                        data_result_hi <= hi_n;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
